// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the ALU command sequencer:
//               opcode and FSM enumerations, the buffered command record and
//               the zero-divisor screen.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_DW    = 32;
  // Tag width carried in the command record. The sequencer's TAG_W
  // parameter must be set to this value.
  localparam int SEQ_TAG_W = 4;

  localparam logic [ALU_DW-1:0] ERR_DIV0_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    REM = 3'd4,
    AND = 3'd5,
    OR  = 3'd6,
    XOR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [ALU_DW-1:0]    a;
    logic [ALU_DW-1:0]    b;
    alu_op_e              op;
    logic [SEQ_TAG_W-1:0] tag;
  } alu_cmd_t;

  // Divide and remainder by zero never reach the ALU.
  function automatic logic is_div0(input alu_cmd_t cmd);
    return ((cmd.op == DIV) || (cmd.op == REM)) && (cmd.b == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_fifo
// Description : DEPTH-entry synchronous FIFO of alu_cmd_t. Registered storage;
//               a pushed entry becomes visible at the head one cycle later.
// Revision    : 1.0 - initial release
// Ports       : clk_i   - clock, rising edge
//               rst_i   - asynchronous active-low reset (empties the FIFO)
//               push_i  - write din_i (ignored when full)
//               pop_i   - advance the head (ignored when empty)
//               din_i   - command to write
//               dout_o  - command at the head (valid when !empty_o)
//               full_o  - occupancy equals DEPTH
//               empty_o - occupancy is zero
//               count_o - occupancy
// ============================================================================
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  alu_cmd_t               din_i,
  output alu_cmd_t               dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  alu_cmd_t      r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= din_i;
  end

  assign dout_o  = r_mem[r_rd_ptr];
  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Buffers tagged ALU commands, issues them one at a time over
//               the ALU valid/ready handshake, and returns each result with
//               its tag. Divide/remainder by zero is answered locally and a
//               stalled ALU is abandoned after TIMEOUT cycles.
// Revision    : 1.0 - initial release
// Ports       : clk_i, rst_i (async active-low)
//               cmd_*   - producer command channel (valid/ready)
//               alu_*   - ALU issue/result interface
//               rsp_*   - consumer response channel (valid/ready)
//               count_o - command FIFO occupancy
// ============================================================================
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = SEQ_TAG_W,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [31:0]            cmd_a_i,
  input  logic [31:0]            cmd_b_i,
  input  logic [2:0]             cmd_op_i,
  input  logic [TAG_W-1:0]       cmd_tag_i,
  output logic                   alu_valid_o,
  output logic [31:0]            alu_operand_a_o,
  output logic [31:0]            alu_operand_b_o,
  output logic [2:0]             alu_operation_o,
  input  logic                   alu_ready_i,
  input  logic [31:0]            alu_result_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [31:0]            rsp_result_o,
  output logic [TAG_W-1:0]       rsp_tag_o,
  output logic                   rsp_err_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int             TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TMR_LAST = TW'(TIMEOUT - 1);

  seq_state_e      r_state;
  seq_state_e      w_next;
  alu_cmd_t        w_push_cmd;
  alu_cmd_t        w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_div0;
  logic [TW-1:0]   r_timer;
  logic [31:0]     r_alu_a;
  logic [31:0]     r_alu_b;
  alu_op_e         r_alu_op;
  logic [31:0]     r_rsp_result;
  logic [TAG_W-1:0] r_rsp_tag;
  logic            r_rsp_err;

  assign w_push_cmd.a   = cmd_a_i;
  assign w_push_cmd.b   = cmd_b_i;
  assign w_push_cmd.op  = alu_op_e'(cmd_op_i);
  assign w_push_cmd.tag = cmd_tag_i;

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cmd_valid_i),
    .pop_i   (w_pop),
    .din_i   (w_push_cmd),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (count_o)
  );

  // Ready depends only on registered occupancy, never on this cycle's pop.
  assign cmd_ready_o = !w_full;
  assign w_div0      = is_div0(w_head);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = w_div0 ? RESP : ISSUE;
        end
      end
      ISSUE: w_next = WAIT;
      // A ready in the final timeout cycle still wins over the abort.
      WAIT: begin
        if (alu_ready_i || (r_timer == TMR_LAST)) w_next = RESP;
      end
      RESP: begin
        if (rsp_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Issue operands are loaded only for commands that go to the ALU, so a
  // screened divide leaves the ALU-facing bus untouched.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_timer      <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= ADD;
      r_rsp_result <= '0;
      r_rsp_tag    <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_rsp_tag <= w_head.tag;
            if (w_div0) begin
              r_rsp_result <= ERR_DIV0_RESULT;
              r_rsp_err    <= 1'b1;
            end else begin
              r_alu_a  <= w_head.a;
              r_alu_b  <= w_head.b;
              r_alu_op <= w_head.op;
            end
          end
        end
        ISSUE: r_timer <= '0;
        WAIT: begin
          if (alu_ready_i) begin
            r_rsp_result <= alu_result_i;
            r_rsp_err    <= 1'b0;
          end else if (r_timer == TMR_LAST) begin
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_valid_o     = (r_state == ISSUE);
  assign alu_operand_a_o = r_alu_a;
  assign alu_operand_b_o = r_alu_b;
  assign alu_operation_o = r_alu_op;
  assign rsp_valid_o     = (r_state == RESP);
  assign rsp_result_o    = r_rsp_result;
  assign rsp_tag_o       = r_rsp_tag;
  assign rsp_err_o       = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer. A behavioural ALU
//               answers issues; expected responses come from a reference
//               function applied to each accepted command.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  tag;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_a_i = '0;
  logic [31:0] cmd_b_i = '0;
  logic [2:0]  cmd_op_i = '0;
  logic [3:0]  cmd_tag_i = '0;
  logic        alu_valid_o;
  logic [31:0] alu_operand_a_o;
  logic [31:0] alu_operand_b_o;
  logic [2:0]  alu_operation_o;
  logic        alu_ready_i = 1'b0;
  logic [31:0] alu_result_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_result_o;
  logic [3:0]  rsp_tag_o;
  logic        rsp_err_o;
  logic [2:0]  count_o;

  int   checks = 0;
  int   failures = 0;
  rsp_t exp_q[$];
  rsp_t obs_q[$];

  // ALU model controls
  logic        alu_hang = 1'b0;
  logic        alu_rand_lat = 1'b0;
  logic        alu_kick = 1'b0;
  logic        alu_pend = 1'b0;
  int          alu_cnt = 0;
  logic [31:0] alu_res = '0;
  logic        rsp_rand = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_a_i         (cmd_a_i),
    .cmd_b_i         (cmd_b_i),
    .cmd_op_i        (cmd_op_i),
    .cmd_tag_i       (cmd_tag_i),
    .alu_valid_o     (alu_valid_o),
    .alu_operand_a_o (alu_operand_a_o),
    .alu_operand_b_o (alu_operand_b_o),
    .alu_operation_o (alu_operation_o),
    .alu_ready_i     (alu_ready_i),
    .alu_result_i    (alu_result_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_result_o    (rsp_result_o),
    .rsp_tag_o       (rsp_tag_o),
    .rsp_err_o       (rsp_err_o),
    .count_o         (count_o)
  );

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd4:    return (b == 0) ? a : a % b;
      3'd5:    return a & b;
      3'd6:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // What the consumer should see for one accepted command.
  function automatic rsp_t ref_rsp(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, input logic [3:0] tag,
                                   input logic hang);
    rsp_t r;
    r.tag = tag;
    if ((op == 3'd3 || op == 3'd4) && b == 0) begin
      r.result = 32'hFFFF_FFFF; r.err = 1'b1;
    end else if (hang) begin
      r.result = 32'd0; r.err = 1'b1;
    end else begin
      r.result = alu_fn(a, b, op); r.err = 1'b0;
    end
    return r;
  endfunction

  // Behavioural ALU: answers an issue after a latency, drives junk otherwise.
  always @(posedge clk) begin
    #1;
    alu_ready_i  = alu_kick;
    alu_result_i = $urandom;
    if (!rst_i) begin
      alu_pend = 1'b0;
    end else begin
      if (alu_pend) begin
        if (alu_cnt == 0) begin
          alu_ready_i  = 1'b1;
          alu_result_i = alu_res;
          alu_pend     = 1'b0;
        end else begin
          alu_cnt--;
        end
      end
      if (alu_valid_o && !alu_hang) begin
        alu_pend = 1'b1;
        alu_cnt  = alu_rand_lat ? int'($urandom_range(0, 3)) : 0;
        alu_res  = alu_fn(alu_operand_a_o, alu_operand_b_o, alu_operation_o);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rsp_rand) rsp_ready_i = 1'($urandom_range(0, 1));
  end

  // Response collector.
  always @(negedge clk) begin
    if (rst_i && rsp_valid_o && rsp_ready_i)
      obs_q.push_back('{rsp_result_o, rsp_tag_o, rsp_err_o});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [3:0] tag);
    int waited = 0;
    cmd_valid_i = 1'b1; cmd_a_i = a; cmd_b_i = b; cmd_op_i = op; cmd_tag_i = tag;
    forever begin
      @(negedge clk);
      if (cmd_ready_o) break;
      waited++;
      if (waited > 300) break;
    end
    if (waited > 300) begin
      checks++; failures++;
      $display("FAIL send_accept: tag %0d not accepted within 300 cycles", tag);
    end else begin
      @(posedge clk); #1;
      exp_q.push_back(ref_rsp(a, b, op, tag, alu_hang));
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (obs_q.size() < exp_q.size()) begin
      failures++;
      $display("FAIL %s_drain: got %0d responses want %0d", name, obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", count_o); end
    checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_o); end
    checks++; if (alu_valid_o !== 1'b0) begin failures++; $display("FAIL reset_alu_valid: got %b want 0", alu_valid_o); end
    checks++; if ({alu_operand_a_o, alu_operand_b_o, alu_operation_o} !== 67'd0) begin
      failures++; $display("FAIL reset_alu_bus: got a=%h b=%h op=%0d want 0", alu_operand_a_o, alu_operand_b_o, alu_operation_o);
    end
    checks++; if ({rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o} !== 38'd0) begin
      failures++; $display("FAIL reset_rsp: got v=%b res=%h tag=%h err=%b want 0", rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o);
    end
    rst_i = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    int n_alu = 0, first_alu = 0, n_rsp = 0;
    rsp_t got = '0;
    rsp_ready_i = 1'b1;
    send(32'd5, 32'd7, 3'd0, 4'd3);
    for (int n = 1; n <= 40 && n_rsp == 0; n++) begin
      @(negedge clk);
      if (alu_valid_o) begin n_alu++; if (first_alu == 0) first_alu = n; end
      if (rsp_valid_o) begin n_rsp = n; got = '{rsp_result_o, rsp_tag_o, rsp_err_o}; end
    end
    @(posedge clk); #1;
    checks++; if (n_alu != 1) begin failures++; $display("FAIL add_valid_pulses: got %0d want 1", n_alu); end
    checks++; if (first_alu != 2) begin failures++; $display("FAIL add_issue_cycle: got %0d want 2", first_alu); end
    checks++; if (n_rsp != 4) begin failures++; $display("FAIL add_rsp_cycle: got %0d want 4", n_rsp); end
    checks++; if (got !== {32'd12, 4'd3, 1'b0}) begin
      failures++; $display("FAIL add_rsp: got res=%0d tag=%0d err=%b want res=12 tag=3 err=0", got.result, got.tag, got.err);
    end
    wait_rsp("add");
    checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL add_count: got %0d want 1", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_div_zero();
    int n_alu = 0, n_rsp = 0;
    rsp_t got = '0;
    rsp_ready_i = 1'b1;
    send(32'd100, 32'd0, 3'd3, 4'd9);
    for (int n = 1; n <= 40 && n_rsp == 0; n++) begin
      @(negedge clk);
      if (alu_valid_o) n_alu++;
      if (rsp_valid_o) begin n_rsp = n; got = '{rsp_result_o, rsp_tag_o, rsp_err_o}; end
    end
    @(posedge clk); #1;
    checks++; if (n_alu != 0) begin failures++; $display("FAIL div0_alu_pulses: got %0d want 0", n_alu); end
    checks++; if (n_rsp != 2) begin failures++; $display("FAIL div0_rsp_cycle: got %0d want 2", n_rsp); end
    checks++; if (got !== {32'hFFFF_FFFF, 4'd9, 1'b1}) begin
      failures++; $display("FAIL div0_rsp: got res=%h tag=%0d err=%b want res=ffffffff tag=9 err=1", got.result, got.tag, got.err);
    end
    wait_rsp("div0");
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_fill_backpressure();
    logic [31:0] a6, b6;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++)
      send($urandom, $urandom | 32'd1, 3'($urandom_range(0, 7)), 4'(i));
    @(negedge clk);
    checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL fill_count: got %0d want 4", count_o); end
    checks++; if (cmd_ready_o !== 1'b0) begin failures++; $display("FAIL fill_ready: got %b want 0", cmd_ready_o); end
    a6 = $urandom; b6 = $urandom | 32'd1;
    cmd_valid_i = 1'b1; cmd_a_i = a6; cmd_b_i = b6; cmd_op_i = 3'd1; cmd_tag_i = 4'd5;
    repeat (3) begin
      @(negedge clk);
      checks++; if (count_o !== 3'd4 || cmd_ready_o !== 1'b0) begin
        failures++; $display("FAIL fill_stall: got count=%0d ready=%b want count=4 ready=0", count_o, cmd_ready_o);
      end
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    send(a6, b6, 3'd1, 4'd5);
    wait_rsp("fill");
    checks++; if (obs_q.size() != 6) begin failures++; $display("FAIL fill_total: got %0d responses want 6", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL fill_rsp[%0d]: got res=%h tag=%0d err=%b want res=%h tag=%0d err=%b",
                             i, obs_q[i].result, obs_q[i].tag, obs_q[i].err, exp_q[i].result, exp_q[i].tag, exp_q[i].err);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    int first_alu = 0, n_rsp = 0;
    rsp_ready_i = 1'b1;
    alu_hang = 1'b1;
    send($urandom, $urandom, 3'd2, 4'd5);
    for (int n = 1; n <= TIMEOUT + 40 && n_rsp == 0; n++) begin
      @(negedge clk);
      if (alu_valid_o && first_alu == 0) first_alu = n;
      if (rsp_valid_o) n_rsp = n;
    end
    @(posedge clk); #1;
    checks++; if (n_rsp - first_alu != TIMEOUT + 1) begin
      failures++; $display("FAIL timeout_latency: got %0d cycles issue-to-rsp want %0d", n_rsp - first_alu, TIMEOUT + 1);
    end
    wait_rsp("timeout");
    alu_hang = 1'b0;
    send(32'd40, 32'd2, 3'd0, 4'd6);
    wait_rsp("after_timeout");
    checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL timeout_total: got %0d responses want 2", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL timeout_rsp[%0d]: got res=%h tag=%0d err=%b want res=%h tag=%0d err=%b",
                             i, obs_q[i].result, obs_q[i].tag, obs_q[i].err, exp_q[i].result, exp_q[i].tag, exp_q[i].err);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_wait();
    int spurious = 0;
    rsp_ready_i = 1'b1;
    alu_hang = 1'b1;
    for (int i = 1; i <= 3; i++) send($urandom, $urandom | 32'd1, 3'd0, 4'(i));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (count_o !== 3'd2 || alu_valid_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      failures++; $display("FAIL rst_mid_pre: got count=%0d alu_v=%b rsp_v=%b want 2 0 0", count_o, alu_valid_o, rsp_valid_o);
    end
    #2 rst_i = 1'b0;
    #1;
    checks++; if (count_o !== 3'd0 || cmd_ready_o !== 1'b1) begin
      failures++; $display("FAIL rst_mid_fifo: got count=%0d ready=%b want 0 1", count_o, cmd_ready_o);
    end
    checks++; if ({alu_valid_o, alu_operand_a_o, alu_operand_b_o, alu_operation_o} !== 68'd0) begin
      failures++; $display("FAIL rst_mid_alu: got v=%b a=%h b=%h op=%0d want 0", alu_valid_o, alu_operand_a_o, alu_operand_b_o, alu_operation_o);
    end
    checks++; if ({rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o} !== 38'd0) begin
      failures++; $display("FAIL rst_mid_rsp: got v=%b res=%h tag=%h err=%b want 0", rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_err_o);
    end
    exp_q.delete(); obs_q.delete();
    @(negedge clk);
    rst_i = 1'b1;
    alu_hang = 1'b0;
    @(negedge clk);
    alu_kick = 1'b1;
    @(negedge clk);
    alu_kick = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid_o || alu_valid_o || count_o != 0) spurious++;
    end
    checks++; if (spurious != 0 || obs_q.size() != 0) begin
      failures++; $display("FAIL rst_late_ready: got %0d active cycles and %0d responses want 0 0", spurious, obs_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_simul_push_pop();
    int n = 0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom, $urandom | 32'd1, 3'($urandom_range(0, 7)), 4'(8 + i));
    while (n < 40) begin
      @(negedge clk);
      if (rsp_valid_o) break;
      n++;
    end
    checks++; if (count_o !== 3'd2 || rsp_valid_o !== 1'b1) begin
      failures++; $display("FAIL simul_setup: got count=%0d rsp_v=%b want 2 1", count_o, rsp_valid_o);
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL simul_idle: got rsp_v=%b want 0", rsp_valid_o); end
    send(32'd9, 32'd4, 3'd6, 4'd11);
    @(negedge clk);
    checks++; if (count_o !== 3'd2) begin failures++; $display("FAIL simul_count: got %0d want 2", count_o); end
    @(posedge clk); #1;
    wait_rsp("simul");
    checks++; if (obs_q.size() != 4) begin failures++; $display("FAIL simul_total: got %0d responses want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL simul_rsp[%0d]: got res=%h tag=%0d err=%b want res=%h tag=%0d err=%b",
                             i, obs_q[i].result, obs_q[i].tag, obs_q[i].err, exp_q[i].result, exp_q[i].tag, exp_q[i].err);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic [31:0] b;
    rsp_rand = 1'b1;
    alu_rand_lat = 1'b1;
    for (int i = 0; i < 24; i++) begin
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      send($urandom, b, 3'($urandom_range(0, 7)), 4'(i));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_rsp("random");
    rsp_rand = 1'b0;
    alu_rand_lat = 1'b0;
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    checks++; if (obs_q.size() != 24) begin failures++; $display("FAIL random_total: got %0d responses want 24", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL random_rsp[%0d]: got res=%h tag=%0d err=%b want res=%h tag=%0d err=%b",
                             i, obs_q[i].result, obs_q[i].tag, obs_q[i].err, exp_q[i].result, exp_q[i].tag, exp_q[i].err);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_div_zero();
    test_fill_backpressure();
    test_timeout();
    test_reset_mid_wait();
    test_simul_push_pop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream stage for the 32-bit ALU. It buffers tagged commands from a producer in a small FIFO and issues them one at a time over the ALU valid/ready handshake. It captures each ALU result and returns it with its tag on a response valid/ready channel. It also screens divide/remainder-by-zero and times out a stalled ALU.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TAG_W, 4, width of command/response tag
TIMEOUT, 16, max cycles in WAIT before aborting (>=2)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  FIFO can accept
cmd_a_i  input  32  operand A
cmd_b_i  input  32  operand B
cmd_op_i  input  3  opcode: 0 add, 1 sub, 2 mul, 3 div, 4 rem, 5 and, 6 or, 7 xor
cmd_tag_i  input  TAG_W  command tag
alu_valid_o  output  1  issue strobe to ALU (ALU valid_i)
alu_operand_a_o  output  32  to ALU operand_a
alu_operand_b_o  output  32  to ALU operand_b
alu_operation_o  output  3  to ALU operation
alu_ready_i  input  1  ALU ready_o
alu_result_i  input  32  ALU result
rsp_valid_o  output  1  response present
rsp_ready_i  input  1  consumer accepts
rsp_result_o  output  32  result
rsp_tag_o  output  TAG_W  tag of the originating command
rsp_err_o  output  1  1 = div/rem by zero or timeout
count_o  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_i low, async): FIFO empty, count_o=0, cmd_ready_o=1, FSM=IDLE, all alu_* and rsp_* outputs 0, timeout counter 0.
- FIFO: registered, not fall-through. Push on cmd_valid_i && cmd_ready_o. cmd_ready_o = (count_o != DEPTH), with no combinational dependence on pop. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if count_o != 0, pop head into the hold register.
  - If op is 3 or 4 and B == 0, go to RESP with result 32'hFFFF_FFFF and err=1.
  - Otherwise go to ISSUE.
- ISSUE: alu_valid_o=1 for exactly one cycle; go to WAIT and clear the timeout counter.
- alu_operand_*/alu_operation_o hold the popped command from ISSUE through the end of WAIT. They are otherwise held at their last value; alu_valid_o is the only qualifier.
- WAIT:
  - On alu_ready_i=1, capture alu_result_i and go to RESP with err=0.
  - Otherwise increment the counter. When it reaches TIMEOUT-1, go to RESP with result 0 and err=1.
  - alu_ready_i is ignored in every state except WAIT.
- RESP: rsp_valid_o=1 with result, tag and err stable until rsp_ready_i=1. On the handshake, go to IDLE. The next pop can occur in the following cycle, so back-to-back throughput is 1 command per 4 cycles.
- Latency with an ALU asserting ready one cycle after valid:
  - Command accepted at edge 0.
  - Pop in cycle 1.
  - alu_valid_o in cycle 2.
  - alu_ready_i in cycle 3.
  - rsp_valid_o from cycle 4.
  - Zero-divisor responses appear in cycle 2.
- Responses are returned in command order. Exactly one response per accepted command unless reset intervenes.
- Reset mid-operation: the in-flight command and FIFO contents are discarded, with no response. A late alu_ready_i after reset is ignored.
- Width: opcodes and operands pass unmodified. The sequencer performs no arithmetic beyond the zero-divisor compare.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum (ADD=0 … XOR=7)
  - ALU_DW=32
  - seq_state_e {IDLE, ISSUE, WAIT, RESP}
  - alu_cmd_t struct {a, b, op, tag}
  - ERR_DIV0_RESULT = 32'hFFFF_FFFF
- One sub-module, alu_cmd_fifo: a parameterised DEPTH x alu_cmd_t synchronous FIFO with push/pop/full/empty/count. The FSM stays in the top level.

Test Plan:
- Single add: cmd a=5, b=7, op=0, tag=3; ALU model returns 12 one cycle after valid -> rsp_valid_o in cycle 4, result=12, tag=3, err=0; alu_valid_o high exactly 1 cycle.
- Div by zero: a=100, b=0, op=3, tag=9 -> no alu_valid_o pulse; rsp result=32'hFFFF_FFFF, err=1, tag=9, in cycle 2.
- Fill/backpressure: rsp_ready_i=0, push 6 commands back-to-back. The first is popped, then 4 fill the FIFO, so cmd_ready_o drops with count_o=4 and the 6th is stalled. Release rsp_ready_i -> all 6 responses in tag order, no loss or duplication.
- Timeout: ALU model never asserts ready for an op=2 command -> rsp result=0, err=1 after TIMEOUT cycles in WAIT; the next command issues normally.
- Reset mid-WAIT: assert rst_i low during WAIT with 2 entries queued -> all outputs 0 immediately, count_o=0, no responses. A late alu_ready_i pulse after reset produces no response.
- Simultaneous push/pop: with count_o=2, push during the IDLE pop cycle -> count_o stays 2, order preserved.
